// File: rtl/pll_supervisor.sv
// PLL lock supervisor: lock synchroniser and sequencing FSM, downstream reset
// release, lock-loss bookkeeping, and per-channel divided clock-enable strobes.

module pll_sup_chdiv #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 enable,
    input  logic                 wr,
    input  logic [DIV_WIDTH-1:0] wr_val,
    output logic                 pulse
);
    logic [DIV_WIDTH-1:0] div_q, cnt_q, term;

    // Divisors 0 and 1 both mean "every cycle".
    assign term = (div_q <= DIV_WIDTH'(1)) ? '0 : div_q - DIV_WIDTH'(1);

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            div_q <= DIV_WIDTH'(1);
            cnt_q <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (wr) begin
                div_q <= wr_val;
                cnt_q <= '0;
            end else if (run && enable) begin
                if (cnt_q >= term) begin
                    cnt_q <= '0;
                    pulse <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + DIV_WIDTH'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end
endmodule

module pll_supervisor #(
    parameter int NUM_CH             = 4,
    parameter int DIV_WIDTH          = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 pll_locked,
    input  logic                 div_wr,
    input  logic [CH_W-1:0]      div_ch,
    input  logic [DIV_WIDTH-1:0] div_val,
    input  logic [NUM_CH-1:0]    ch_enable,
    input  logic                 clear_lost,
    output logic                 sys_reset,
    output logic                 ready,
    output logic [NUM_CH-1:0]    clk_en,
    output logic                 lock_lost,
    output logic [7:0]           relock_count
);
    localparam int MAXC = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                          LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, HOLD_RESET, RUN} state_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            sync1_q, lock_s;
    logic            lost_set;
    logic [NUM_CH-1:0] pulse_v, wr_v;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            lock_s  <= sync1_q;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            sys_reset <= 1'b1;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            sys_reset <= (state_n != RUN);
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        lost_set = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                cnt_n = '0;
                if (lock_s) state_n = STABILIZE;
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_n = HOLD_RESET;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            HOLD_RESET: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt_q == CW'(RESET_HOLD_CYCLES - 1)) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            default: begin
                if (!lock_s) begin
                    state_n  = WAIT_LOCK;
                    cnt_n    = '0;
                    lost_set = 1'b1;
                end
            end
        endcase
    end

    assign ready = (state_q == RUN);

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            lock_lost    <= 1'b0;
            relock_count <= '0;
        end else begin
            if (lost_set) lock_lost <= 1'b1;
            else if (clear_lost) lock_lost <= 1'b0;
            if (lost_set && relock_count != 8'hFF) relock_count <= relock_count + 8'd1;
        end
    end

    // The strobe register can still be set on the RUN exit edge; gating by
    // ready keeps the output quiet from that edge on.
    assign clk_en = pulse_v & {NUM_CH{ready}};

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign wr_v[i] = div_wr && (32'(div_ch) == i);
            pll_sup_chdiv #(.DIV_WIDTH(DIV_WIDTH)) u_div (
                .clock_in (clock_in),
                .reset    (reset),
                .run      (ready),
                .enable   (ch_enable[i]),
                .wr       (wr_v[i]),
                .wr_val   (div_val),
                .pulse    (pulse_v[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor; expected values go through a scoreboard
// queue and are checked with immediate assertions.

module tb_pll_supervisor;
    localparam int LSC = 16;
    localparam int RHC = 8;
    localparam int STARTUP_LAT = 2 + 1 + LSC + RHC;

    logic        clock_in = 1'b0;
    logic        reset = 1'b1;
    logic        pll_locked = 1'b0;
    logic        div_wr = 1'b0;
    logic [1:0]  div_ch = '0;
    logic [15:0] div_val = '0;
    logic [3:0]  ch_enable = '0;
    logic [2:0]  ch_enable3 = '0;
    logic        clear_lost = 1'b0;
    logic        sys_reset, ready, lock_lost;
    logic [3:0]  clk_en;
    logic [7:0]  relock_count;
    logic        sys_reset3, ready3, lock_lost3;
    logic [2:0]  clk_en3;
    logic [7:0]  relock_count3;

    pll_supervisor #(.NUM_CH(4), .DIV_WIDTH(16), .LOCK_STABLE_CYCLES(LSC),
                     .RESET_HOLD_CYCLES(RHC)) dut (
        .clock_in(clock_in), .reset(reset), .pll_locked(pll_locked),
        .div_wr(div_wr), .div_ch(div_ch), .div_val(div_val),
        .ch_enable(ch_enable), .clear_lost(clear_lost),
        .sys_reset(sys_reset), .ready(ready), .clk_en(clk_en),
        .lock_lost(lock_lost), .relock_count(relock_count));

    // Three-channel copy: its 2-bit div_ch can carry an out-of-range index.
    pll_supervisor #(.NUM_CH(3), .DIV_WIDTH(16), .LOCK_STABLE_CYCLES(LSC),
                     .RESET_HOLD_CYCLES(RHC)) dut3 (
        .clock_in(clock_in), .reset(reset), .pll_locked(pll_locked),
        .div_wr(div_wr), .div_ch(div_ch), .div_val(div_val),
        .ch_enable(ch_enable3), .clear_lost(clear_lost),
        .sys_reset(sys_reset3), .ready(ready3), .clk_en(clk_en3),
        .lock_lost(lock_lost3), .relock_count(relock_count3));

    always #5 clock_in = ~clock_in;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %0h required an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        push(tag, exp);
        pop_chk(obs);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    // Raise lock and count edges until ready, bounded.
    task automatic startup(output int lat, output logic rst_ok);
        lat = 0;
        rst_ok = 1'b1;
        pll_locked = 1'b1;
        while (!ready && lat < 200) begin
            tick();
            lat++;
            if (!ready && sys_reset !== 1'b1) rst_ok = 1'b0;
        end
    endtask

    task automatic write_div(input logic [1:0] ch, input logic [15:0] val);
        div_wr = 1'b1;
        div_ch = ch;
        div_val = val;
    endtask

    initial begin
        int   lat;
        logic ok;
        logic [3:0] e4;
        logic [2:0] e3;

        // Reset state
        tick(3);
        chk("reset_outputs", {sys_reset, ready, lock_lost, clk_en}, {1'b1, 1'b0, 1'b0, 4'b0});
        chk("reset_relock", relock_count, 0);
        reset = 1'b0;
        tick(2);
        chk("wait_no_lock", {sys_reset, ready}, 2'b10);

        // Startup latency
        startup(lat, ok);
        chk("startup_latency", lat, STARTUP_LAT);
        chk("startup_sysreset_held", ok, 1);
        chk("run_outputs", {sys_reset, ready, lock_lost}, 3'b010);
        chk("dut3_run", {sys_reset3, ready3, lock_lost3, relock_count3}, {3'b010, 8'd0});

        // Divisors written with channels disabled, then enabled together
        write_div(2'd0, 16'd3); tick();
        write_div(2'd1, 16'd0); tick();
        write_div(2'd2, 16'd5); tick();
        div_wr = 1'b0;
        chk("div_idle", clk_en, 0);
        for (int k = 1; k <= 34; k++) begin
            logic en2, b2;
            en2 = (k <= 15) || (k >= 23);
            b2 = (k <= 15) ? (k % 5 == 0) : (k >= 23) ? ((k - 22) % 5 == 0) : 1'b0;
            ch_enable = {1'b0, en2, 2'b11};
            e4 = {1'b0, b2, 1'b1, (k % 3 == 0)};
            push($sformatf("divider_k%0d", k), e4);
            tick();
            pop_chk(clk_en);
        end

        // Divisor rewrite mid-count
        write_div(2'd0, 16'd4); tick();
        div_wr = 1'b0;
        chk("rw_w0", clk_en[0], 0);
        tick(); chk("rw_w0p1", clk_en[0], 0);
        tick(); chk("rw_w0p2", clk_en[0], 0);
        write_div(2'd0, 16'd2); tick();
        div_wr = 1'b0;
        chk("rw_w1", clk_en[0], 0);
        tick(); chk("rw_w1p1", clk_en[0], 0);
        tick(); chk("rw_w1p2", clk_en[0], 1);
        tick(); chk("rw_w1p3", clk_en[0], 0);
        tick(); chk("rw_w1p4", clk_en[0], 1);

        // Out-of-range channel write on the three-channel copy
        write_div(2'd3, 16'd7); tick();
        div_wr = 1'b0;
        ch_enable3 = 3'b111;
        for (int k = 1; k <= 10; k++) begin
            e3 = {(k % 5 == 0), 1'b1, (k % 2 == 0)};
            push($sformatf("bad_ch_k%0d", k), e3);
            tick();
            pop_chk(clk_en3);
        end

        // Loss in RUN: lock_s falls two edges after the drop, FSM leaves RUN on the next
        pll_locked = 1'b0;
        tick(2);
        chk("loss_pre", ready, 1);
        tick();
        chk("loss_outputs", {sys_reset, ready, lock_lost, clk_en}, {3'b101, 4'b0});
        chk("loss_count1", relock_count, 1);

        // Saturation of relock_count
        for (int i = 0; i < 299; i++) begin
            startup(lat, ok);
            pll_locked = 1'b0;
            tick(3);
        end
        chk("relock_saturate", relock_count, 255);
        clear_lost = 1'b1; tick();
        clear_lost = 1'b0;
        chk("clear_lost", lock_lost, 0);

        // Clear on the same edge as a loss: set wins
        startup(lat, ok);
        pll_locked = 1'b0;
        tick(2);
        clear_lost = 1'b1; tick();
        clear_lost = 1'b0;
        chk("set_beats_clear", {lock_lost, ready}, 2'b10);

        // Glitch during STABILIZE at stability count 10
        tick(5);
        pll_locked = 1'b1;
        tick(12);
        pll_locked = 1'b0;
        tick(3);
        chk("glitch_no_ready", ready, 0);
        chk("glitch_lost_unchanged", lock_lost, 1);
        chk("glitch_count_unchanged", relock_count, 255);
        startup(lat, ok);
        chk("glitch_relatency", lat, STARTUP_LAT);

        // Async reset between edges in RUN
        #3 reset = 1'b1;
        #1;
        chk("async_outputs", {sys_reset, ready, lock_lost, clk_en}, {3'b100, 4'b0});
        chk("async_relock", relock_count, 0);
        tick(2);
        reset = 1'b0;
        startup(lat, ok);
        chk("post_reset_latency", lat, STARTUP_LAT);
        chk("post_reset_flags", {lock_lost, relock_count}, 9'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
